// File: rtl/pending_encoder_32to5.sv
// Sticky 32-line event capture with a priority-encoded 5-bit index offered
// under a valid/ack handshake; only the acknowledged bit is cleared.
module pending_encoder_32to5 #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req,
  input  logic [31:0] mask,
  input  logic        ack,
  output logic [4:0]  code,
  output logic        valid,
  output logic [31:0] pending,
  output logic        any
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e      state_q, state_d;
  logic [4:0]  code_q, code_d, enc;
  logic [31:0] pending_q, pending_d, sel, clr;

  assign sel     = pending_q & ~mask;
  assign any     = |sel;
  assign valid   = (state_q == StOffer);
  assign code    = code_q;
  assign pending = pending_q;

  // Later loop iterations overwrite earlier ones, so the last hit wins.
  always_comb begin
    enc = '0;
    if (LOW_FIRST) begin
      for (int i = 31; i >= 0; i--) begin
        if (sel[i]) enc = 5'(i);
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (sel[i]) enc = 5'(i);
      end
    end
  end

  // Set has priority over clear: req is OR-ed in after the clear mask.
  always_comb begin
    clr = '0;
    if (valid && ack) clr[code_q] = 1'b1;
    pending_d = (pending_q & ~clr) | req;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          code_d  = enc;
          state_d = StOffer;
        end
      end
      StOffer: begin
        if (ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      code_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_pending_encoder_32to5.sv
// Drives a low-first and a high-first instance with shared stimulus and
// checks both against a behavioural model every cycle, plus pinned literals.
module tb_pending_encoder_32to5;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic [31:0] mask;
  logic        ack;

  logic [4:0]  d_code    [2];
  logic        d_valid   [2];
  logic [31:0] d_pending [2];
  logic        d_any     [2];

  pending_encoder_32to5 #(.LOW_FIRST(1'b1)) u_lo (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .code(d_code[0]), .valid(d_valid[0]), .pending(d_pending[0]), .any(d_any[0])
  );

  pending_encoder_32to5 #(.LOW_FIRST(1'b0)) u_hi (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .code(d_code[1]), .valid(d_valid[1]), .pending(d_pending[1]), .any(d_any[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: lowest set index = log2 of isolated low bit,
  // highest set index = floor(log2(sel)).
  function automatic logic [4:0] pick(input logic [31:0] sel, input bit low_first);
    longint s;
    s = longint'(sel);
    if (low_first) return 5'($clog2(s & -s));
    return 5'($clog2(s + 1) - 1);
  endfunction

  function automatic logic [31:0] f_pend(input logic r, input logic [31:0] p, input logic v,
                                         input logic [4:0] c, input logic a,
                                         input logic [31:0] q);
    logic [31:0] np;
    if (r) return '0;
    np = p;
    if (v && a) np[c] = 1'b0;
    return np | q;
  endfunction

  function automatic logic f_valid(input logic r, input logic v, input logic a,
                                   input logic [31:0] p, input logic [31:0] m);
    if (r) return 1'b0;
    if (v) return !a;
    return (p & ~m) != 0;
  endfunction

  function automatic logic [4:0] f_code(input logic r, input logic v, input logic [4:0] c,
                                        input logic [31:0] p, input logic [31:0] m,
                                        input bit lf);
    if (r) return '0;
    if (!v && ((p & ~m) != 0)) return pick(p & ~m, lf);
    return c;
  endfunction

  logic [31:0] m_pend  [2];
  logic [4:0]  m_code  [2];
  logic        m_valid [2];
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k]  <= f_pend(rst, m_pend[k], m_valid[k], m_code[k], ack, req);
      m_valid[k] <= f_valid(rst, m_valid[k], ack, m_pend[k], mask);
      m_code[k]  <= f_code(rst, m_valid[k], m_code[k], m_pend[k], mask, (k == 0));
    end
    if (rst) m_live <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cmp%0d pending", k), d_pending[k], m_pend[k]);
        chk($sformatf("cmp%0d valid", k), 32'(d_valid[k]), 32'(m_valid[k]));
        chk($sformatf("cmp%0d code", k), 32'(d_code[k]), 32'(m_code[k]));
        chk($sformatf("cmp%0d any", k), 32'(d_any[k]), 32'((m_pend[k] & ~mask) != 0));
      end
    end
  end

  // Apply inputs, let one rising edge consume them, return 1 unit after it.
  task automatic cyc(input logic r, input logic [31:0] q, input logic [31:0] m,
                     input logic a);
    rst = r; req = q; mask = m; ack = a;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] got [2][3];

  initial begin
    rst = 1'b1; req = '0; mask = '0; ack = 1'b0;
    @(posedge clk);
    #1;

    // Reset overrides req.
    cyc(1'b1, 32'hFFFF_FFFF, '0, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFF, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("t1 pending", d_pending[k], 32'h0);
      chk("t1 valid", 32'(d_valid[k]), 32'd0);
      chk("t1 code", 32'(d_code[k]), 32'd0);
      chk("t1 any", 32'(d_any[k]), 32'd0);
    end

    // Single event, two cycles to valid.
    cyc(1'b0, 32'h0002_0000, '0, 1'b0);
    chk("t2 pending", d_pending[0], 32'h0002_0000);
    chk("t2 valid early", 32'(d_valid[0]), 32'd0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("t2 valid", 32'(d_valid[0]), 32'd1);
    chk("t2 code", 32'(d_code[0]), 32'd17);
    chk("t2 code hi", 32'(d_code[1]), 32'd17);
    cyc(1'b0, '0, '0, 1'b1);
    chk("t2 cleared", d_pending[0], 32'h0);
    chk("t2 valid off", 32'(d_valid[0]), 32'd0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("t2 valid stays", 32'(d_valid[0]), 32'd0);

    // Priority order in both directions.
    cyc(1'b0, 32'h8000_0011, '0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      cyc(1'b0, '0, '0, 1'b0);
      got[0][n] = d_code[0];
      got[1][n] = d_code[1];
      chk("t3 valid", 32'(d_valid[0]), 32'd1);
      cyc(1'b0, '0, '0, 1'b1);
      chk("t3 gap", 32'(d_valid[0]), 32'd0);
    end
    chk("t3 lo0", 32'(got[0][0]), 32'd0);
    chk("t3 lo1", 32'(got[0][1]), 32'd4);
    chk("t3 lo2", 32'(got[0][2]), 32'd31);
    chk("t3 hi0", 32'(got[1][0]), 32'd31);
    chk("t3 hi1", 32'(got[1][1]), 32'd4);
    chk("t3 hi2", 32'(got[1][2]), 32'd0);

    // Set beats clear.
    cyc(1'b0, 32'h20, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("t4 code", 32'(d_code[0]), 32'd5);
    cyc(1'b0, 32'h20, '0, 1'b1);
    chk("t4 pending kept", d_pending[0], 32'h20);
    chk("t4 valid gap", 32'(d_valid[0]), 32'd0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("t4 reoffer", 32'(d_valid[0]), 32'd1);
    chk("t4 recode", 32'(d_code[0]), 32'd5);
    cyc(1'b0, '0, '0, 1'b1);

    // Masking.
    cyc(1'b0, 32'h21, 32'h1, 1'b0);
    cyc(1'b0, '0, 32'h1, 1'b0);
    chk("t5 code lo", 32'(d_code[0]), 32'd5);
    chk("t5 code hi", 32'(d_code[1]), 32'd5);
    cyc(1'b0, '0, 32'h1, 1'b1);
    chk("t5 pending", d_pending[0], 32'h1);
    chk("t5 any off", 32'(d_any[0]), 32'd0);
    cyc(1'b0, '0, 32'h1, 1'b0);
    chk("t5 valid idle", 32'(d_valid[0]), 32'd0);
    mask = '0;
    #1;
    chk("t5 any on", 32'(d_any[0]), 32'd1);
    cyc(1'b0, '0, '0, 1'b0);
    chk("t5 code0", 32'(d_code[0]), 32'd0);
    chk("t5 valid0", 32'(d_valid[0]), 32'd1);
    cyc(1'b0, '0, 32'hFFFF_FFFF, 1'b0);
    chk("t5 held valid", 32'(d_valid[0]), 32'd1);
    chk("t5 held code", 32'(d_code[0]), 32'd0);
    chk("t5 masked any", 32'(d_any[0]), 32'd0);
    cyc(1'b0, '0, '0, 1'b1);

    // Reset mid-offer, then a stray ack.
    cyc(1'b0, 32'h0000_0600, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("t6 code lo", 32'(d_code[0]), 32'd9);
    chk("t6 code hi", 32'(d_code[1]), 32'd10);
    cyc(1'b1, '0, '0, 1'b0);
    chk("t6 pending", d_pending[0], 32'h0);
    chk("t6 valid", 32'(d_valid[0]), 32'd0);
    chk("t6 code", 32'(d_code[0]), 32'd0);
    cyc(1'b0, '0, '0, 1'b1);
    chk("t6 stray pending", d_pending[0], 32'h0);
    chk("t6 stray valid", 32'(d_valid[0]), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0),
          $urandom & $urandom & $urandom & $urandom,
          ($urandom_range(0, 3) == 0) ? $urandom : 32'h0,
          1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
